// File: rtl/demux_1ton_flit_if.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1ton_flit_if
//  Brief    : Flit input handshake and per-port output bundle for the
//             1-to-N buffered flit demultiplexer.
//  Revision : 1.0  initial release
// ============================================================================
interface demux_1ton_flit_if #(
  parameter int DATA_W    = 16,
  parameter int NUM_PORTS = 5,
  parameter int SEL_W     = $clog2(NUM_PORTS)
);
  // Upstream side (flit source into the demux)
  logic [DATA_W-1:0]           data_i;
  logic                        valid_i;
  logic                        head_i;
  logic                        tail_i;
  logic [SEL_W-1:0]            sel_i;
  logic                        ready_o;
  // Downstream side (per-port FIFO heads toward the output arbiters)
  logic [NUM_PORTS*DATA_W-1:0] data_o;
  logic [NUM_PORTS-1:0]        valid_o;
  logic [NUM_PORTS-1:0]        ready_i;
  // Status
  logic                        locked_o;
  logic                        drop_o;
  logic [15:0]                 drop_cnt_o;

  // Environment side: drives flits and downstream ready
  modport master (
    output data_i, valid_i, head_i, tail_i, sel_i, ready_i,
    input  ready_o, data_o, valid_o, locked_o, drop_o, drop_cnt_o
  );

  // Demux side
  modport slave (
    input  data_i, valid_i, head_i, tail_i, sel_i, ready_i,
    output ready_o, data_o, valid_o, locked_o, drop_o, drop_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/demux_1ton_flit.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1ton_flit
//  Brief    : Buffered 1-to-N flit demultiplexer with per-output FIFOs and a
//             wormhole route lock held from head flit to tail flit.
//             Optional macro DEMUX_DROP_CNT_EN enables the saturating
//             dropped-flit counter; otherwise drop_cnt_o is tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module demux_1ton_flit #(
  parameter  int DATA_W     = 16,
  parameter  int NUM_PORTS  = 5,
  parameter  int FIFO_DEPTH = 2,
  localparam int SEL_W      = $clog2(NUM_PORTS)
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  demux_1ton_flit_if.slave  bus
);

  localparam int                PTR_W      = $clog2(FIFO_DEPTH);
  localparam int                CNT_W      = PTR_W + 1;
  localparam logic [SEL_W:0]    PORT_LIMIT = (SEL_W+1)'(NUM_PORTS);
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [SEL_W-1:0]     lock_sel, lock_sel_nxt;
  logic [SEL_W-1:0]     tgt;
  logic                 sel_legal;
  logic                 drop_cond;
  logic                 tgt_full;
  logic                 ready;
  logic                 accept;
  logic                 write_en;
  logic                 drop_q;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;
  logic [NUM_PORTS-1:0] valid;

  // Route target, drop decision and input ready; never looks at ready_i
  always_comb begin
    tgt       = (state == LOCKED) ? lock_sel : bus.sel_i;
    sel_legal = ({1'b0, bus.sel_i} < PORT_LIMIT);
    drop_cond = (state == IDLE) &&
                ((bus.valid_i && !bus.head_i) || (bus.head_i && !sel_legal));
    tgt_full  = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (tgt == SEL_W'(p)) tgt_full = full[p];
    end
    ready    = drop_cond || !tgt_full;
    accept   = bus.valid_i && ready;
    write_en = accept && !drop_cond;
  end

  // Next-state: a legal multi-flit head locks the route, the tail releases it
  always_comb begin
    state_nxt    = state;
    lock_sel_nxt = lock_sel;
    if (write_en) begin
      case (state)
        IDLE: begin
          if (bus.head_i && !bus.tail_i) begin
            state_nxt    = LOCKED;
            lock_sel_nxt = bus.sel_i;
          end
        end
        LOCKED: begin
          if (bus.tail_i) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and locked route register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      lock_sel <= '0;
    end else begin
      state    <= state_nxt;
      lock_sel <= lock_sel_nxt;
    end
  end

  // One-cycle pulse after an accepted flit is discarded
  always_ff @(posedge clk_i) begin
    if (rst_i) drop_q <= 1'b0;
    else       drop_q <= accept && drop_cond;
  end

`ifdef DEMUX_DROP_CNT_EN
  logic [15:0] drop_cnt;

  // Saturating count of dropped flits, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (rst_i)                              drop_cnt <= '0;
    else if (drop_q && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end

  assign bus.drop_cnt_o = drop_cnt;
`else
  assign bus.drop_cnt_o = 16'h0000;
`endif

  // Per-output FIFO; ports are independent so a stalled port only blocks input
  // while it is the current target
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_fifo
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    assign full[p]  = (count == FULL_CNT);
    assign valid[p] = (count != '0);
    assign push[p]  = write_en && (tgt == SEL_W'(p));
    assign pop[p]   = valid[p] && bus.ready_i[p];

    // Storage, pointers and occupancy; memory is cleared so data_o reads 0 after reset
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
        if (push[p]) begin
          mem[wr_ptr] <= bus.data_i;
          wr_ptr      <= wr_ptr + PTR_W'(1);
        end
        if (pop[p]) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push[p], pop[p]})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end

    assign bus.data_o[p*DATA_W +: DATA_W] = mem[rd_ptr];
  end

  assign bus.valid_o  = valid;
  assign bus.ready_o  = ready;
  assign bus.locked_o = (state == LOCKED);
  assign bus.drop_o   = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_1ton_flit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_1ton_flit
//  Brief    : Scoreboard bench for demux_1ton_flit with directed flit vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux_1ton_flit;

  localparam int DATA_W = 16;
  localparam int NP     = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [DATA_W-1:0] exp_q [NP][$];

  always #5 clk = ~clk;

  demux_1ton_flit_if #(.DATA_W(DATA_W), .NUM_PORTS(NP)) bus ();

  demux_1ton_flit #(
    .DATA_W     (DATA_W),
    .NUM_PORTS  (NP),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Scoreboard monitor: every pop that will happen at the next edge is compared
  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < NP; p++) begin
        if (bus.valid_o[p] && bus.ready_i[p]) begin
          checks++;
          if (exp_q[p].size() == 0) begin
            failures++;
            $display("FAIL port%0d_unexpected got=%h required=none", p,
                     bus.data_o[p*DATA_W +: DATA_W]);
          end else begin
            logic [DATA_W-1:0] e;
            e = exp_q[p].pop_front();
            if (bus.data_o[p*DATA_W +: DATA_W] !== e) begin
              failures++;
              $display("FAIL port%0d_data got=%h required=%h", p,
                       bus.data_o[p*DATA_W +: DATA_W], e);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  // Present one flit, wait (bounded) for acceptance, record expectation,
  // then check drop_o one cycle after the accepting edge
  task automatic send(input logic [15:0] d, input logic h, input logic t,
                      input logic [2:0] s, input int port, input bit drop);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    bus.data_i  = d;
    bus.head_i  = h;
    bus.tail_i  = t;
    bus.sel_i   = s;
    bus.valid_i = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (bus.ready_o) begin
        ok = 1'b1;
        if (!drop) exp_q[port].push_back(d);
      end else begin
        n++;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout got=ready_o_low required=accept data=%h", d);
      bus.valid_i = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      chk("drop_pulse", {31'd0, bus.drop_o}, {31'd0, drop});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.data_i  = '0;
    bus.valid_i = 1'b0;
    bus.head_i  = 1'b0;
    bus.tail_i  = 1'b0;
    bus.sel_i   = '0;
    bus.ready_i = 5'h1F;
    rst         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_valid",    {27'd0, bus.valid_o}, 32'd0);
    chk("rst_data",     bus.data_o[31:0], 32'd0);
    chk("rst_data_hi",  {16'd0, bus.data_o[79:64]}, 32'd0);
    chk("rst_locked",   {31'd0, bus.locked_o}, 32'd0);
    chk("rst_drop",     {31'd0, bus.drop_o}, 32'd0);
    chk("rst_drop_cnt", {16'd0, bus.drop_cnt_o}, 32'd0);
    chk("rst_ready",    {31'd0, bus.ready_o}, 32'd1);

    // Single-flit packets to each port in turn; only that port shows valid
    for (int p = 0; p < NP; p++) begin
      send(16'h5555, 1'b1, 1'b1, 3'(p), p, 1'b0);
      chk("single_onehot", {27'd0, bus.valid_o}, 32'd1 << p);
    end
    repeat (2) @(posedge clk);
    #1;

    // Wormhole packet to port 3; sel_i moves to 1 mid-packet
    send(16'hA001, 1'b1, 1'b0, 3'd3, 3, 1'b0);
    chk("lock_after_head", {31'd0, bus.locked_o}, 32'd1);
    send(16'hA002, 1'b0, 1'b0, 3'd1, 3, 1'b0);
    chk("lock_after_body", {31'd0, bus.locked_o}, 32'd1);
    send(16'hA003, 1'b0, 1'b1, 3'd1, 3, 1'b0);
    chk("lock_after_tail", {31'd0, bus.locked_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Port 2 back-pressure blocks input; port 0 still drains
    bus.ready_i = 5'b11010;
    send(16'hC000, 1'b1, 1'b1, 3'd0, 0, 1'b0);
    send(16'hB001, 1'b1, 1'b1, 3'd2, 2, 1'b0);
    send(16'hB002, 1'b1, 1'b1, 3'd2, 2, 1'b0);
    bus.data_i  = 16'hB003;
    bus.head_i  = 1'b1;
    bus.tail_i  = 1'b1;
    bus.sel_i   = 3'd2;
    bus.valid_i = 1'b1;
    @(negedge clk);
    chk("full_blocks_ready", {31'd0, bus.ready_o}, 32'd0);
    @(posedge clk);
    #1;
    bus.ready_i = 5'b11011;
    @(posedge clk);
    #1;
    chk("port0_drained", {31'd0, bus.valid_o[0]}, 32'd0);
    chk("still_blocked", {31'd0, bus.ready_o}, 32'd0);
    bus.valid_i = 1'b0;
    bus.ready_i = 5'h1F;
    send(16'hB003, 1'b1, 1'b1, 3'd2, 2, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Fill port 2, then release while pushing: push and pop overlap
    bus.ready_i = 5'b11011;
    send(16'hD001, 1'b1, 1'b1, 3'd2, 2, 1'b0);
    send(16'hD002, 1'b1, 1'b1, 3'd2, 2, 1'b0);
    chk("port2_full_valid", {31'd0, bus.valid_o[2]}, 32'd1);
    bus.ready_i = 5'h1F;
    send(16'hD003, 1'b1, 1'b1, 3'd2, 2, 1'b0);
    chk("push_pop_valid", {31'd0, bus.valid_o[2]}, 32'd1);
    repeat (3) @(posedge clk);
    #1;

    // Orphan body and illegal-select head are accepted and dropped
    send(16'hE001, 1'b0, 1'b0, 3'd0, 0, 1'b1);
    send(16'hE002, 1'b1, 1'b0, 3'd6, 0, 1'b1);
    chk("drop_no_valid", {27'd0, bus.valid_o}, 32'd0);
    chk("drop_no_lock",  {31'd0, bus.locked_o}, 32'd0);
    @(posedge clk);
    #1;
`ifdef DEMUX_DROP_CNT_EN
    chk("drop_cnt_two", {16'd0, bus.drop_cnt_o}, 32'd2);
`else
    chk("drop_cnt_off", {16'd0, bus.drop_cnt_o}, 32'd0);
`endif
    // Body after the dropped head is an orphan too
    send(16'hE003, 1'b0, 1'b1, 3'd0, 0, 1'b1);
    @(posedge clk);
    #1;
`ifdef DEMUX_DROP_CNT_EN
    chk("drop_cnt_three", {16'd0, bus.drop_cnt_o}, 32'd3);
`else
    chk("drop_cnt_off2", {16'd0, bus.drop_cnt_o}, 32'd0);
`endif

    // Reset mid-packet with data held in FIFOs
    bus.ready_i = 5'h00;
    send(16'hF001, 1'b1, 1'b0, 3'd1, 1, 1'b0);
    send(16'hF002, 1'b0, 1'b0, 3'd0, 1, 1'b0);
    chk("mid_pkt_locked", {31'd0, bus.locked_o}, 32'd1);
    chk("mid_pkt_valid1", {31'd0, bus.valid_o[1]}, 32'd1);
    rst = 1'b1;
    for (int p = 0; p < NP; p++) exp_q[p].delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst2_valid",    {27'd0, bus.valid_o}, 32'd0);
    chk("rst2_locked",   {31'd0, bus.locked_o}, 32'd0);
    chk("rst2_drop_cnt", {16'd0, bus.drop_cnt_o}, 32'd0);
    bus.ready_i = 5'h1F;
    send(16'hF003, 1'b0, 1'b0, 3'd1, 1, 1'b1);
    chk("rst2_orphan_no_valid", {27'd0, bus.valid_o}, 32'd0);

    // Everything expected must have come out
    repeat (5) @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      chk("queue_empty", exp_q[p].size(), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
